// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage. Holds HI/LO, runs
// mult/multu/div/divu over a fixed cycle count and mthi/mtlo in one cycle.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic        md_start,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        hilo_sel,
   output logic [31:0] md_rdata,
   output logic        busy,
   output logic        md_stall
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [2:0]    op_q;
   logic [31:0]   a_q, b_q;
   logic [31:0]   hi_q, lo_q;

   logic          long_op;   // md_start with a multi-cycle op this cycle
   logic          accept, commit, wr_hi, wr_lo;

   assign long_op = md_start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state: IDLE -> RUN on a long op, RUN -> IDLE when the counter expires
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (long_op) state_d = S_RUN;
         S_RUN:   if (cnt_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs/strobes decoded from state; md ops while busy are dropped
   always_comb begin
      busy   = (state_q == S_RUN);
      accept = (state_q == S_IDLE) && long_op;
      commit = (state_q == S_RUN) && (cnt_q == '0);
      wr_hi  = (state_q == S_IDLE) && md_start && (md_op == OP_MTHI);
      wr_lo  = (state_q == S_IDLE) && md_start && (md_op == OP_MTLO);
   end

   assign md_stall = busy | long_op;
   assign md_rdata = hilo_sel ? hi_q : lo_q;

   // Results from the captured operands; signed divide goes through
   // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no trap.
   logic [63:0] prod_s, prod_u;
   logic        is_sdiv, neg_a, neg_b, div_zero;
   logic [31:0] mag_a, mag_b, mag_b_nz, uq, ur, quo, rem;

   // Arithmetic for the in-flight op
   always_comb begin
      prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u   = {32'd0, a_q} * {32'd0, b_q};
      is_sdiv  = (op_q == OP_DIV);
      neg_a    = is_sdiv && a_q[31];
      neg_b    = is_sdiv && b_q[31];
      mag_a    = neg_a ? (~a_q + 32'd1) : a_q;
      mag_b    = neg_b ? (~b_q + 32'd1) : b_q;
      div_zero = (b_q == 32'd0);
      mag_b_nz = div_zero ? 32'd1 : mag_b;
      uq       = mag_a / mag_b_nz;
      ur       = mag_a % mag_b_nz;
      quo      = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      rem      = neg_a ? (~ur + 32'd1) : ur;
   end

   // Datapath: counter, operand capture and HI/LO updates
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (accept) begin
            op_q  <= md_op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            cnt_q <= (md_op == OP_MULT || md_op == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
         end else if (busy && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (commit) begin
            case (op_q)
               OP_MULT:  begin hi_q <= prod_s[63:32]; lo_q <= prod_s[31:0]; end
               OP_MULTU: begin hi_q <= prod_u[63:32]; lo_q <= prod_u[31:0]; end
               OP_DIV, OP_DIVU: if (!div_zero) begin hi_q <= rem; lo_q <= quo; end
               default: ;
            endcase
         end
         if (wr_hi) hi_q <= rs_val;
         if (wr_lo) lo_q <= rs_val;
      end
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline.
- Executes mult, multu, div and divu over a fixed number of cycles, and mthi/mtlo in one cycle.
- Holds the architectural HI/LO registers and returns HI or LO for mfhi/mflo.
- Exports busy status to the stall unit. The stall unit holds any md instruction in D while this unit is occupied. The mfhi/mflo result travels down the pipe and is forwarded as an M/W-stage value.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- md_op  input  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- md_start  input  1  E-stage instruction is valid (not a bubble or flush) and md_op is live this cycle
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- hilo_sel  input  1  0 reads LO, 1 reads HI
- md_rdata  output  32  combinational: hilo_sel ? HI : LO
- busy  output  1  registered; high while a mult/div is in flight
- md_stall  output  1  combinational: busy | (md_start & md_op in 1..4); stall unit consumes it

Behaviour:
- Reset (reset==0, asynchronous), all cleared:
  - HI=0, LO=0, busy=0, counter=0.
  - Pending result and operand latches discarded.
  - Any in-flight operation is abandoned and never commits.
  - After reset release, the unit is IDLE.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE, md_start=1, md_op in 1..4:
  - Capture rs_val/rt_val and md_op.
  - Load counter with (MULT_CYCLES or DIV_CYCLES) - 1.
  - Go to RUN. busy=1 from the next cycle.
- RUN:
  - Each edge decrements the counter.
  - On the edge where counter==0: commit the result to HI/LO, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles.
  - A new md op can be accepted on the first cycle busy=0.
- Results are computed from the operands captured at start; later changes on rs_val/rt_val have no effect.
- mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0].
- multu: unsigned 32x32 -> 64, HI=[63:32], LO=[31:0].
- div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
- divu: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (div/divu, rt captured ==0): runs the full DIV_CYCLES, then HI/LO are left unchanged. No exception is raised.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE with md_start=1: HI (or LO) <= rs_val on that edge. busy stays 0.
- md_start with any md_op while busy=1: ignored. The stall unit prevents this case; the unit must still not corrupt state.
- md_start=0: md_op is ignored.
- While busy, HI/LO and md_rdata show the old committed values.
- The commit edge and a same-cycle mthi/mtlo cannot coincide, because md_stall blocks them.
- md_rdata reflects the HI/LO register contents only. There is no bypass of a same-edge write.

Test Plan:
- Reset: after reset release, HI=LO=0, busy=0. Pulse reset low mid-div → busy=0 immediately, HI/LO=0, no later commit.
- mult rs=0xFFFFFFFF, rt=2 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 → LO=14, HI=2.
- Divide by zero: first mthi 0x1234, then mtlo 0x5678; then div rs=9, rt=0 → busy 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- Operand hold: start mult 3*4, then change rs_val/rt_val every cycle while busy → HI=0, LO=12. md_stall=1 during the start cycle and all busy cycles.
- Back-to-back: mtlo 0xAA, then mult issued the following cycle → LO=0xAA readable with hilo_sel=0 during busy. A second mult asserted while busy is ignored. A mult issued on the first non-busy cycle is accepted.
